adc_capture_sequencer: RTL and testbench
========================================

ADC_CAPTURE_SEQUENCER -- requirements
Module: adc_capture_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning per-channel ADC sample width.
REQ-002 SHALL have parameter CNT_W, default 24, meaning width of the capture length and sample counter.
REQ-003 SHALL have port adc_data_clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port arm  input  1  one-cycle pulse; starts a capture request.
REQ-006 SHALL have port abort  input  1  one-cycle pulse; cancels any capture in progress.
REQ-007 SHALL have port trig_mode  input  2  00 immediate, 01 ch1 rising threshold, 10 ch1 falling threshold, 11 external.
REQ-008 SHALL have port ext_trig  input  1  external trigger level, already synchronous to adc_data_clk.
REQ-009 SHALL have port threshold  input  DATA_W  signed two's-complement trigger level.
REQ-010 SHALL have port capture_len  input  CNT_W  number of samples to write.
REQ-011 SHALL have port adc_ready  input  1  MMCM locked AND IDELAY ready.
REQ-012 SHALL have port data_valid  input  1  frame-aligned sample strobe.
REQ-013 SHALL have ports adc_data_1, adc_data_2  input  DATA_W  channel 1 and channel 2 samples.
REQ-014 SHALL have port fifo_prog_full  input  1  FIFO programmable-full flag.
REQ-015 SHALL have port fifo_busy  input  1  FIFO reset in progress.
REQ-016 SHALL have port fifo_din  output  2*DATA_W  {adc_data_1, adc_data_2}.
REQ-017 SHALL have port fifo_wr_en  output  1  FIFO write strobe.
REQ-018 SHALL have ports busy (1), done (1 pulse), overflow (1 sticky), fault (1 sticky), sample_count (CNT_W), state (3), all outputs.

Function
REQ-019 SHALL implement states IDLE=0, WAIT_RDY=1, ARMED=2, CAPTURE=3, DONE=4, exposed on state.
REQ-020 SHALL, in IDLE on arm: latch trig_mode, threshold and capture_len; clear overflow, fault and sample_count; go to WAIT_RDY.
REQ-021 SHALL ignore arm in every state other than IDLE.
REQ-022 SHALL go from WAIT_RDY to ARMED on the first cycle with adc_ready=1 and fifo_busy=0.
REQ-023 SHALL, when latched capture_len=0, go from WAIT_RDY directly to DONE with no FIFO write.
REQ-024 SHALL, in ARMED, evaluate the trigger only on data_valid cycles; mode 00 fires on the first one.
REQ-025 SHALL fire mode 01 when prev_ch1 < threshold and cur_ch1 >= threshold (signed); mode 10 when prev_ch1 > threshold and cur_ch1 <= threshold.
REQ-026 SHALL set prev_ch1 valid only after one data_valid sample in ARMED; no threshold trigger on the first sample.
REQ-027 SHALL fire mode 11 on a data_valid cycle where ext_trig=1 and ext_trig was 0 on the previous data_valid cycle.
REQ-028 SHALL treat the triggering sample as capture sample 1 and enter CAPTURE on the following cycle.
REQ-029 SHALL register fifo_din and fifo_wr_en: one-cycle latency from the qualifying data_valid cycle.
REQ-030 SHALL, in CAPTURE, write on each data_valid cycle with fifo_prog_full=0 and fifo_busy=0, incrementing sample_count per write.
REQ-031 SHALL, on a data_valid cycle with fifo_prog_full=1 or fifo_busy=1, drop the sample, set overflow, and continue; the sample_count is not incremented.
REQ-032 SHALL enter DONE on the cycle sample_count reaches capture_len; no further writes.
REQ-033 SHALL, on adc_ready=0 in ARMED or CAPTURE, set fault and enter DONE.
REQ-034 SHALL, on abort in any non-IDLE state, enter IDLE with no done pulse; abort wins over arm, trigger and completion in the same cycle.
REQ-035 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE.
REQ-036 SHALL assert busy in WAIT_RDY, ARMED and CAPTURE.
REQ-037 SHALL hold sample_count, overflow and fault until the next accepted arm.
REQ-038 SHALL saturate sample_count and never wrap.

Reset
REQ-039 SHALL, on reset, go to IDLE with fifo_wr_en=0, fifo_din=0, busy=0, done=0, overflow=0, fault=0, sample_count=0, prev-valid flags=0.
REQ-040 SHALL, on reset asserted mid-capture, suppress any write pending for the next cycle.

Verification
REQ-041 Mode 00, capture_len=8, data_valid every cycle, ready -> 8 wr_en pulses, done at count 8, sample_count=8.
REQ-042 Mode 01, threshold=100, ch1 ramp 90,95,100 -> first write carries ch1=100; 95 is not written.
REQ-043 prog_full high for 3 valid cycles mid-capture, capture_len=16 -> 16 writes total, overflow=1, done asserted.
REQ-044 abort and arm in the same cycle during CAPTURE -> IDLE, no done pulse, the arm is ignored.
REQ-045 adc_ready drops after 5 writes -> fault=1, one-cycle done, sample_count=5.
REQ-046 capture_len=0 -> done within 2 cycles of ready, zero writes; reset mid-capture -> wr_en low on the next cycle.

Source files
------------

// File: rtl/adc_capture_sequencer_if.sv
// ADC sample stream in, FIFO write port out, seen from the capture sequencer.
interface adc_capture_sequencer_if #(
  parameter int unsigned DATA_W = 16
);
  logic                  data_valid;
  logic [DATA_W-1:0]     adc_data_1;
  logic [DATA_W-1:0]     adc_data_2;
  logic                  fifo_prog_full;
  logic                  fifo_busy;
  logic [2*DATA_W-1:0]   fifo_din;
  logic                  fifo_wr_en;

  // Sequencer side: consumes samples and FIFO status, drives the write port.
  modport master (
    input  data_valid, adc_data_1, adc_data_2, fifo_prog_full, fifo_busy,
    output fifo_din, fifo_wr_en
  );

  // Environment side: ADC front end and FIFO.
  modport slave (
    output data_valid, adc_data_1, adc_data_2, fifo_prog_full, fifo_busy,
    input  fifo_din, fifo_wr_en
  );
endinterface

// File: rtl/adc_capture_sequencer.sv
// Capture sequencer: arms on request, waits for ADC/FIFO readiness, detects a
// trigger on the sample stream, then writes capture_len two-channel samples
// into the FIFO, dropping (and flagging) samples the FIFO cannot take.
module adc_capture_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 24
) (
  input  logic                    adc_data_clk,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    abort,
  input  logic [1:0]              trig_mode,
  input  logic                    ext_trig,
  input  logic [DATA_W-1:0]       threshold,
  input  logic [CNT_W-1:0]        capture_len,
  input  logic                    adc_ready,
  adc_capture_sequencer_if.master bus,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic                    fault,
  output logic [CNT_W-1:0]        sample_count,
  output logic [2:0]              state
);

  localparam int unsigned ST_W  = 3;
  localparam int unsigned DIN_W = 2 * DATA_W;

  typedef enum logic [ST_W-1:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_ARMED    = 3'd2,
    S_CAPTURE  = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [1:0] M_IMM  = 2'b00;
  localparam logic [1:0] M_RISE = 2'b01;
  localparam logic [1:0] M_FALL = 2'b10;
  localparam logic [1:0] M_EXT  = 2'b11;

  state_t                    st_q,        st_nx;
  logic [1:0]                mode_q,      mode_nx;
  logic signed [DATA_W-1:0]  thr_q,       thr_nx;
  logic [CNT_W-1:0]          len_q,       len_nx;
  logic signed [DATA_W-1:0]  prev_ch1_q,  prev_ch1_nx;
  logic                      prev_ext_q,  prev_ext_nx;
  logic                      prev_vld_q,  prev_vld_nx;
  logic [CNT_W-1:0]          cnt_q,       cnt_nx;
  logic                      ovf_q,       ovf_nx;
  logic                      flt_q,       flt_nx;
  logic                      wr_en_q;
  logic [DIN_W-1:0]          din_q,       din_nx;
  logic                      busy_q,      done_q;

  logic                      trig_c;
  logic                      accept_c;
  logic                      take_c;
  logic                      wr_c;
  logic [CNT_W-1:0]          cnt_inc_c;
  logic signed [DATA_W-1:0]  cur_ch1_c;

  assign cur_ch1_c = $signed(bus.adc_data_1);
  assign accept_c  = ~bus.fifo_prog_full & ~bus.fifo_busy;
  assign cnt_inc_c = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  // Trigger condition for the current sample in the latched mode.
  always_comb begin
    trig_c = 1'b0;
    case (mode_q)
      M_IMM:  trig_c = 1'b1;
      M_RISE: trig_c = prev_vld_q && (prev_ch1_q < thr_q) && (cur_ch1_c >= thr_q);
      M_FALL: trig_c = prev_vld_q && (prev_ch1_q > thr_q) && (cur_ch1_c <= thr_q);
      M_EXT:  trig_c = prev_vld_q && !prev_ext_q && ext_trig;
      default: trig_c = 1'b0;
    endcase
  end

  // Next-state and next-register values.
  always_comb begin
    st_nx       = st_q;
    mode_nx     = mode_q;
    thr_nx      = thr_q;
    len_nx      = len_q;
    prev_ch1_nx = prev_ch1_q;
    prev_ext_nx = prev_ext_q;
    prev_vld_nx = prev_vld_q;
    cnt_nx      = cnt_q;
    ovf_nx      = ovf_q;
    flt_nx      = flt_q;
    din_nx      = din_q;
    take_c      = 1'b0;
    wr_c        = 1'b0;

    unique case (st_q)
      S_IDLE: begin
        if (arm) begin
          mode_nx     = trig_mode;
          thr_nx      = $signed(threshold);
          len_nx      = capture_len;
          cnt_nx      = '0;
          ovf_nx      = 1'b0;
          flt_nx      = 1'b0;
          prev_vld_nx = 1'b0;
          prev_ext_nx = 1'b0;
          st_nx       = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (abort) begin
          st_nx = S_IDLE;
        end else if (adc_ready && !bus.fifo_busy) begin
          st_nx = (len_q == '0) ? S_DONE : S_ARMED;
        end
      end
      S_ARMED: begin
        if (abort) begin
          st_nx = S_IDLE;
        end else if (!adc_ready) begin
          flt_nx = 1'b1;
          st_nx  = S_DONE;
        end else if (bus.data_valid) begin
          prev_ch1_nx = cur_ch1_c;
          prev_ext_nx = ext_trig;
          prev_vld_nx = 1'b1;
          if (trig_c) begin
            take_c = 1'b1;
            st_nx  = S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        if (abort) begin
          st_nx = S_IDLE;
        end else if (!adc_ready) begin
          flt_nx = 1'b1;
          st_nx  = S_DONE;
        end else if (bus.data_valid) begin
          take_c = 1'b1;
        end
      end
      S_DONE: begin
        st_nx = S_IDLE;
      end
      default: begin
        st_nx = S_IDLE;
      end
    endcase

    // A sample belonging to the capture: write it if the FIFO can take it.
    if (take_c) begin
      if (accept_c) begin
        wr_c   = 1'b1;
        din_nx = {bus.adc_data_1, bus.adc_data_2};
        cnt_nx = cnt_inc_c;
        if (cnt_inc_c == len_q) begin
          st_nx = S_DONE;
        end
      end else begin
        ovf_nx = 1'b1;
      end
    end
  end

  // State and registered outputs; reset also kills a write queued for the next cycle.
  always_ff @(posedge adc_data_clk) begin
    if (reset) begin
      st_q       <= S_IDLE;
      mode_q     <= 2'b00;
      thr_q      <= '0;
      len_q      <= '0;
      prev_ch1_q <= '0;
      prev_ext_q <= 1'b0;
      prev_vld_q <= 1'b0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      flt_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      din_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      st_q       <= st_nx;
      mode_q     <= mode_nx;
      thr_q      <= thr_nx;
      len_q      <= len_nx;
      prev_ch1_q <= prev_ch1_nx;
      prev_ext_q <= prev_ext_nx;
      prev_vld_q <= prev_vld_nx;
      cnt_q      <= cnt_nx;
      ovf_q      <= ovf_nx;
      flt_q      <= flt_nx;
      wr_en_q    <= wr_c;
      din_q      <= din_nx;
      busy_q     <= (st_nx == S_WAIT_RDY) || (st_nx == S_ARMED) || (st_nx == S_CAPTURE);
      done_q     <= (st_nx == S_DONE);
    end
  end

  assign bus.fifo_wr_en = wr_en_q;
  assign bus.fifo_din   = din_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign overflow       = ovf_q;
  assign fault          = flt_q;
  assign sample_count   = cnt_q;
  assign state          = 3'(st_q);

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed bench for adc_capture_sequencer: a sample-level model predicts the
// FIFO write stream and final status for each stimulus vector.
module tb_adc_capture_sequencer;

  typedef struct {
    logic               dv;
    logic signed [15:0] ch1;
    logic [15:0]        ch2;
    logic               full;
    logic               fbusy;
    logic               rdy;
    logic               ext;
    logic               abrt;
    logic               armx;
    logic               rst;
  } stim_t;

  logic        adc_data_clk = 1'b0;
  logic        reset;
  logic        arm;
  logic        abort;
  logic [1:0]  trig_mode;
  logic        ext_trig;
  logic [15:0] threshold;
  logic [23:0] capture_len;
  logic        adc_ready;
  logic        busy, done, overflow, fault;
  logic [23:0] sample_count;
  logic [2:0]  state;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          done_seen = 0;
  int          done_cyc = -1;
  bit          mon_on = 1'b0;
  logic [31:0] exp_q[$];
  stim_t       vec[64];

  adc_capture_sequencer_if #(.DATA_W(16)) bus ();

  adc_capture_sequencer #(.DATA_W(16), .CNT_W(24)) dut (
    .adc_data_clk (adc_data_clk),
    .reset        (reset),
    .arm          (arm),
    .abort        (abort),
    .trig_mode    (trig_mode),
    .ext_trig     (ext_trig),
    .threshold    (threshold),
    .capture_len  (capture_len),
    .adc_ready    (adc_ready),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .fault        (fault),
    .sample_count (sample_count),
    .state        (state)
  );

  always #5 adc_data_clk = ~adc_data_clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Per-cycle checker: write stream against the model queue, status invariants.
  task automatic monitor();
    logic [31:0] w;
    forever begin
      @(negedge adc_data_clk);
      cyc++;
      if (mon_on) begin
        chk("busy_in_active_states", longint'(busy),
            longint'(state == 3'd1 || state == 3'd2 || state == 3'd3));
        chk("done_only_in_done_state", longint'(done), longint'(state == 3'd4));
        if (done) begin
          done_seen++;
          if (done_cyc < 0) done_cyc = cyc;
        end
        if (bus.fifo_wr_en) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: actual din=%h, expected no write", bus.fifo_din);
          end else begin
            w = exp_q.pop_front();
            chk("fifo_din", longint'(bus.fifo_din), longint'(w));
          end
        end
      end
    end
  endtask

  // Sample-level behaviour: find the trigger, then collect writes until length,
  // abort, reset or loss of ADC readiness.
  task automatic model(input logic [1:0] md, input logic signed [15:0] thr, input int len,
                       input int n, output int cnt, output logic ovf, output logic flt,
                       output int dn, output logic [31:0] last, output logic known);
    bit armed = 1'b1;
    bit have_prev = 1'b0;
    bit fire;
    logic signed [15:0] pch1 = '0;
    logic pext = 1'b0;
    cnt = 0; ovf = 1'b0; flt = 1'b0; dn = 0; last = '0; known = 1'b0;
    exp_q.delete();
    if (len == 0) begin
      dn = 1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (vec[i].rst) begin
        cnt = 0; ovf = 1'b0; flt = 1'b0; last = '0; known = 1'b1;
        break;
      end
      if (vec[i].abrt) break;
      if (!vec[i].rdy) begin
        flt = 1'b1; dn = 1;
        break;
      end
      if (!vec[i].dv) continue;
      if (armed) begin
        case (md)
          2'b00:   fire = 1'b1;
          2'b01:   fire = have_prev && (pch1 < thr) && (vec[i].ch1 >= thr);
          2'b10:   fire = have_prev && (pch1 > thr) && (vec[i].ch1 <= thr);
          default: fire = have_prev && !pext && vec[i].ext;
        endcase
        pch1 = vec[i].ch1;
        pext = vec[i].ext;
        have_prev = 1'b1;
        if (!fire) continue;
        armed = 1'b0;
      end
      if (vec[i].full || vec[i].fbusy) begin
        ovf = 1'b1;
      end else begin
        last = {vec[i].ch1, vec[i].ch2};
        known = 1'b1;
        exp_q.push_back(last);
        cnt++;
        if (cnt == len) begin
          dn = 1;
          break;
        end
      end
    end
  endtask

  task automatic fill(input int n, input int b1, input int b2);
    for (int i = 0; i < n; i++) begin
      vec[i] = '{dv: 1'b1, ch1: 16'(b1 + i), ch2: 16'(b2 + i), full: 1'b0, fbusy: 1'b0,
                 rdy: 1'b1, ext: 1'b0, abrt: 1'b0, armx: 1'b0, rst: 1'b0};
    end
  endtask

  task automatic drive_idle();
    reset = 1'b0; arm = 1'b0; abort = 1'b0; adc_ready = 1'b1; ext_trig = 1'b0;
    bus.data_valid = 1'b0; bus.adc_data_1 = '0; bus.adc_data_2 = '0;
    bus.fifo_prog_full = 1'b0; bus.fifo_busy = 1'b0;
  endtask

  task automatic apply(input int i);
    reset = vec[i].rst; arm = vec[i].armx; abort = vec[i].abrt;
    adc_ready = vec[i].rdy; ext_trig = vec[i].ext;
    bus.data_valid = vec[i].dv; bus.adc_data_1 = vec[i].ch1; bus.adc_data_2 = vec[i].ch2;
    bus.fifo_prog_full = vec[i].full; bus.fifo_busy = vec[i].fbusy;
  endtask

  task automatic run_test(input string nm, input logic [1:0] md, input logic signed [15:0] thr,
                          input int len, input int n, input int e_cnt, input logic e_ovf,
                          input logic e_flt, input int e_done, input logic [31:0] e_first,
                          input int max_lat);
    int m_cnt, m_done, arm_cyc, k;
    logic m_ovf, m_flt, m_known;
    logic [31:0] m_last;
    model(md, thr, len, n, m_cnt, m_ovf, m_flt, m_done, m_last, m_known);
    chk({nm, "/model_count"}, longint'(m_cnt), longint'(e_cnt));
    chk({nm, "/model_overflow"}, longint'(m_ovf), longint'(e_ovf));
    chk({nm, "/model_fault"}, longint'(m_flt), longint'(e_flt));
    chk({nm, "/model_done"}, longint'(m_done), longint'(e_done));
    if (exp_q.size() > 0) chk({nm, "/model_first_word"}, longint'(exp_q[0]), longint'(e_first));

    done_seen = 0;
    done_cyc = -1;
    trig_mode = md; threshold = thr; capture_len = 24'(len); arm = 1'b1;
    @(posedge adc_data_clk); #1;
    arm = 1'b0;
    arm_cyc = cyc;
    @(posedge adc_data_clk); #1;
    for (int i = 0; i < n; i++) begin
      apply(i);
      @(posedge adc_data_clk); #1;
      if (vec[i].rst) begin
        chk({nm, "/wr_en_after_reset"}, longint'(bus.fifo_wr_en), 0);
        chk({nm, "/state_after_reset"}, longint'(state), 0);
      end
    end
    drive_idle();
    k = 0;
    while (state != 3'd0 && k < 12) begin
      @(posedge adc_data_clk); #1;
      k++;
    end
    @(posedge adc_data_clk); #1;
    chk({nm, "/end_state_idle"}, longint'(state), 0);
    chk({nm, "/end_busy"}, longint'(busy), 0);
    chk({nm, "/sample_count"}, longint'(sample_count), longint'(m_cnt));
    chk({nm, "/overflow"}, longint'(overflow), longint'(m_ovf));
    chk({nm, "/fault"}, longint'(fault), longint'(m_flt));
    chk({nm, "/done_pulses"}, longint'(done_seen), longint'(m_done));
    chk({nm, "/missing_writes"}, longint'(exp_q.size()), 0);
    if (m_known) chk({nm, "/held_din"}, longint'(bus.fifo_din), longint'(m_last));
    if (max_lat > 0) chk({nm, "/done_latency_ok"}, longint'(done_cyc > 0 && (done_cyc - arm_cyc) <= max_lat), 1);
    if (state != 3'd0) begin
      abort = 1'b1;
      @(posedge adc_data_clk); #1;
      abort = 1'b0;
    end
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int q[$];
    fork
      monitor();
    join_none
    drive_idle();
    reset = 1'b1; trig_mode = 2'b00; threshold = '0; capture_len = '0;
    repeat (3) @(posedge adc_data_clk);
    #1;
    chk("reset/state", longint'(state), 0);
    chk("reset/wr_en", longint'(bus.fifo_wr_en), 0);
    chk("reset/din", longint'(bus.fifo_din), 0);
    chk("reset/busy", longint'(busy), 0);
    chk("reset/done", longint'(done), 0);
    chk("reset/overflow", longint'(overflow), 0);
    chk("reset/fault", longint'(fault), 0);
    chk("reset/sample_count", longint'(sample_count), 0);
    reset = 1'b0;
    mon_on = 1'b1;

    // Immediate trigger, valid every cycle.
    fill(10, 10, 200);
    run_test("imm_len8", 2'b00, 16'sd0, 8, 10, 8, 1'b0, 1'b0, 1, 32'h000A_00C8, 0);

    // Rising threshold: first sample above threshold must not fire.
    fill(7, 0, 500);
    q = '{120, 90, 95, 100, 105, 110, 115};
    foreach (q[i]) vec[i].ch1 = 16'(q[i]);
    run_test("rise_thr100", 2'b01, 16'sd100, 4, 7, 4, 1'b0, 1'b0, 1, 32'h0064_01F7, 0);

    // Falling threshold across zero, signed compare.
    fill(5, 0, 0);
    q = '{10, 20, -60, -70, -80};
    foreach (q[i]) vec[i].ch1 = 16'(q[i]);
    run_test("fall_thr_m50", 2'b10, -16'sd50, 3, 5, 3, 1'b0, 1'b0, 1, 32'hFFC4_0002, 0);

    // External edge, judged only against the previous valid sample.
    fill(8, 1000, 0);
    q = '{1, 1, 0, 1, 0, 1, 1, 0};
    foreach (q[i]) vec[i].ext = q[i][0];
    vec[2].dv = 1'b0;
    run_test("ext_edge", 2'b11, 16'sd0, 2, 8, 2, 1'b0, 1'b0, 1, 32'h03ED_0005, 0);

    // FIFO back-pressure mid-capture.
    fill(24, 0, 256);
    vec[5].full = 1'b1; vec[6].full = 1'b1; vec[7].full = 1'b1;
    vec[10].fbusy = 1'b1;
    vec[12].dv = 1'b0; vec[12].full = 1'b1;
    run_test("prog_full", 2'b00, 16'sd0, 16, 24, 16, 1'b1, 1'b0, 1, 32'h0000_0100, 0);

    // Abort with a simultaneous arm during capture.
    fill(8, 50, 60);
    vec[4].abrt = 1'b1; vec[4].armx = 1'b1;
    run_test("abort_arm", 2'b00, 16'sd0, 10, 8, 4, 1'b0, 1'b0, 0, 32'h0032_003C, 0);

    // ADC readiness lost after five writes.
    fill(9, 300, 400);
    vec[2].dv = 1'b0;
    vec[6].rdy = 1'b0;
    run_test("ready_drop", 2'b00, 16'sd0, 10, 9, 5, 1'b0, 1'b1, 1, 32'h012C_0190, 0);

    // Zero-length capture.
    run_test("len0", 2'b00, 16'sd0, 0, 0, 0, 1'b0, 1'b0, 1, 32'h0, 2);

    // Reset in the middle of a capture.
    fill(6, 7, 9);
    vec[3].rst = 1'b1;
    run_test("reset_mid", 2'b00, 16'sd0, 8, 6, 0, 1'b0, 1'b0, 0, 32'h0007_0009, 0);

    // Length-one capture completes on the trigger sample.
    fill(4, 40, 41);
    run_test("len1", 2'b00, 16'sd0, 1, 4, 1, 1'b0, 1'b0, 1, 32'h0028_0029, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
